uart_rx: RTL and testbench

8N1 UART receiver. It is the receive-side counterpart of the existing UART transmit path. Serial input rx is synchronised and start-bit qualified, then sampled at mid-bit using a baud counter. Each good byte goes into a holding register read by the core through the same uart_sel select used on the write side. Status flags: byte_ready, frame_err, overrun.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_if.sv | 40 ++++
 rtl/uart_rx_controller.sv | 77 +++++++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions, common to the receive and transmit paths.
//   DATA_BITS  : payload bits per frame
//   rx_state_e : receive FSM states (StParity only reached when UART_RX_PARITY_EN is defined)
package uart_rx_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Core-side bus of the UART receiver.
//   uart_sel, rd : address select and read strobe from the core (read = uart_sel & rd)
//   data_out     : last accepted byte
//   byte_ready   : unread byte pending
//   frame_err    : sticky, stop bit sampled low
//   overrun      : sticky, byte accepted while one was still unread
//   parity_err   : sticky, even parity mismatch (only with UART_RX_PARITY_EN)
// master = core side, slave = receiver side.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                 uart_sel;
  logic                 rd;
  logic [DATA_BITS-1:0] data_out;
  logic                 byte_ready;
  logic                 frame_err;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (
    output uart_sel, rd,
    input  data_out, byte_ready, frame_err, overrun, parity_err
  );
  modport slave (
    input  uart_sel, rd,
    output data_out, byte_ready, frame_err, overrun, parity_err
  );
`else
  modport master (
    output uart_sel, rd,
    input  data_out, byte_ready, frame_err, overrun
  );
  modport slave (
    input  uart_sel, rd,
    output data_out, byte_ready, frame_err, overrun
  );
`endif

endinterface

// File: rtl/uart_rx_controller.sv
// Receive FSM with counter-clear and shift-enable decoding.
//   clk, rst   : clock, asynchronous active-low reset
//   rx_s       : synchronised serial input
//   baud_cnt   : bit-period counter from the datapath
//   bit_cnt    : data bit index from the datapath
//   cnt_clr    : state changes on this edge, clear both counters
//   shift_en   : sample rx_s into the shift register
//   stop_tick  : stop bit sample point
//   par_tick   : parity bit sample point (only with UART_RX_PARITY_EN)
module uart_rx_controller
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_s,
  input  logic [CntW-1:0] baud_cnt,
  input  logic [2:0]      bit_cnt,
`ifdef UART_RX_PARITY_EN
  output logic            par_tick,
`endif
  output logic            cnt_clr,
  output logic            shift_en,
  output logic            stop_tick
);

  rx_state_e state_q;
  logic      tick;
  logic      mid;
  logic      advance;

  assign tick = (baud_cnt == CntW'(CLKS_PER_BIT - 1));
  assign mid  = (baud_cnt == CntW'(CLKS_PER_BIT / 2 - 1));

  // Each state has exactly one exit condition, so "leaving" doubles as the counter clear.
  always_comb begin
    advance = 1'b0;
    unique case (state_q)
      StIdle:   advance = ~rx_s;
      StStart:  advance = mid;
      StData:   advance = tick && (bit_cnt == 3'd7);
      StParity: advance = tick;
      StStop:   advance = tick;
      default:  advance = 1'b1;
    endcase
  end

  assign cnt_clr   = advance;
  assign shift_en  = (state_q == StData) && tick;
  assign stop_tick = (state_q == StStop) && tick;
`ifdef UART_RX_PARITY_EN
  assign par_tick  = (state_q == StParity) && tick;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else if (advance) begin
      unique case (state_q)
        StIdle:   state_q <= StStart;
        // Start bit gone high at mid-bit: treat as a glitch.
        StStart:  state_q <= rx_s ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
        StData:   state_q <= StParity;
`else
        StData:   state_q <= StStop;
`endif
        StParity: state_q <= StStop;
        StStop:   state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   rx  : serial line, idle high, asynchronous to clk
//   bus : core-side select/read and status (uart_rx_if.slave)
// Synchroniser, counters, shift register and status registers live here; sequencing is in
// uart_rx_controller.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx,
  uart_rx_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic                 sync1_q;
  logic                 rx_s;
  logic [CntW-1:0]      baud_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 byte_ready_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 cnt_clr;
  logic                 shift_en;
  logic                 stop_tick;
  logic                 rd_hit;
`ifdef UART_RX_PARITY_EN
  logic                 par_tick;
  logic                 par_bad_q;
  logic                 parity_err_q;
`endif

  uart_rx_controller #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .rx_s     (rx_s),
    .baud_cnt (baud_cnt_q),
    .bit_cnt  (bit_cnt_q),
`ifdef UART_RX_PARITY_EN
    .par_tick (par_tick),
`endif
    .cnt_clr  (cnt_clr),
    .shift_en (shift_en),
    .stop_tick(stop_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s    <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      if (cnt_clr || baud_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
        baud_cnt_q <= '0;
      end else begin
        baud_cnt_q <= baud_cnt_q + 1'b1;
      end
      if (cnt_clr) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      // LSB first on the wire: shift right, new bit enters at the MSB.
      if (shift_en) begin
        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
      end
    end
  end

  assign rd_hit = bus.uart_sel & bus.rd;

  // Read clears first; a same-cycle accept then overrides byte_ready (accept wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q       <= '0;
      byte_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (rd_hit) begin
        byte_ready_q <= 1'b0;
        frame_err_q  <= 1'b0;
        overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end
`ifdef UART_RX_PARITY_EN
      if (par_tick) begin
        par_bad_q <= (^shift_q) ^ rx_s;
      end
`endif
      if (stop_tick) begin
        if (rx_s) begin
          data_q       <= shift_q;
          byte_ready_q <= 1'b1;
          if (byte_ready_q && !rd_hit) begin
            overrun_q <= 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          if (par_bad_q) begin
            parity_err_q <= 1'b1;
          end
`endif
        end else begin
          frame_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.byte_ready = byte_ready_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with CLKS_PER_BIT = 16. Expected bytes are queued when a
// well-framed byte is sent and popped once the frame has been received.
module tb_uart_rx;
  localparam int unsigned Cpb = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LatMax = 2 + Cpb / 2 + 9 * Cpb + 1 + Cpb;
`else
  localparam int LatMax = 2 + Cpb / 2 + 9 * Cpb + 1;
`endif

  logic clk;
  logic rst;
  logic rx;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp;
  int         n_err;
  int         cyc;
  int         lat;
  logic       seen;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one bit period starting at a falling edge; optionally pulse a read at index rd_at.
  task automatic hold_bit(input logic v, input int rd_at);
    rx = v;
    for (int i = 0; i < int'(Cpb); i++) begin
      bus.uart_sel = (i == rd_at);
      bus.rd       = (i == rd_at);
      @(negedge clk);
      cyc++;
      if (!seen && bus.byte_ready) begin
        seen = 1'b1;
        lat  = cyc;
      end
    end
    bus.uart_sel = 1'b0;
    bus.rd       = 1'b0;
  endtask

  // Full frame plus one idle bit period. rd_on_stop lands the read on the stop-sample edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v,
                            input logic rd_on_stop);
    cyc  = 0;
    lat  = 0;
    seen = 1'b0;
    if (stop_v) exp_q.push_back(b);
    hold_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) hold_bit(b[i], -1);
`ifdef UART_RX_PARITY_EN
    hold_bit(par_v, -1);
`endif
    hold_bit(stop_v, rd_on_stop ? 10 : -1);
    hold_bit(1'b1, -1);
  endtask

  task automatic expect_byte(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_pending"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_data"}, bus.data_out, e);
      check_eq({tag, "_ready"}, bus.byte_ready, 1);
    end
  endtask

  task automatic read_pulse();
    bus.uart_sel = 1'b1;
    bus.rd       = 1'b1;
    @(negedge clk);
    bus.uart_sel = 1'b0;
    bus.rd       = 1'b0;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b0;
    rx           = 1'b1;
    bus.uart_sel = 1'b0;
    bus.rd       = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_data", bus.data_out, 8'h00);
    check_eq("rst_ready", bus.byte_ready, 0);
    check_eq("rst_ferr", bus.frame_err, 0);
    check_eq("rst_ovr", bus.overrun, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame, then a clean 0x3C.
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("midrst_no_ready", bus.byte_ready, 0);
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0);
    expect_byte("midrst_3c");
    check_eq("midrst_ferr", bus.frame_err, 0);
    check_eq("midrst_ovr", bus.overrun, 0);
    read_pulse();

    // Clean byte with latency bound.
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
    check_eq("a5_latency_ok", (seen && lat <= LatMax), 1);
    expect_byte("a5");
    check_eq("a5_ferr", bus.frame_err, 0);
    check_eq("a5_ovr", bus.overrun, 0);
    read_pulse();
    check_eq("a5_read_clears", bus.byte_ready, 0);
    check_eq("a5_data_held", bus.data_out, 8'hA5);

    // Glitch shorter than half a bit, then a byte to prove the FSM returned to idle.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("glitch_ready", bus.byte_ready, 0);
    check_eq("glitch_ferr", bus.frame_err, 0);
    check_eq("glitch_ovr", bus.overrun, 0);
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
    expect_byte("post_glitch");
    read_pulse();

    // Framing error: stop bit low.
    send_frame(8'h55, 1'b0, ^8'h55, 1'b0);
    check_eq("ferr_set", bus.frame_err, 1);
    check_eq("ferr_ready", bus.byte_ready, 0);
    check_eq("ferr_data_kept", bus.data_out, 8'h5A);
    read_pulse();
    check_eq("ferr_cleared", bus.frame_err, 0);

    // Overrun with no read.
    send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
    expect_byte("ovr_11");
    send_frame(8'h22, 1'b1, ^8'h22, 1'b0);
    expect_byte("ovr_22");
    check_eq("ovr_set", bus.overrun, 1);
    read_pulse();
    check_eq("ovr_cleared", bus.overrun, 0);

    // Read on the exact stop-sample cycle of the second byte: accept wins, no overrun.
    send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
    expect_byte("race_11");
    send_frame(8'h22, 1'b1, ^8'h22, 1'b1);
    expect_byte("race_22");
    check_eq("race_no_ovr", bus.overrun, 0);
    read_pulse();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    expect_byte("par_bad");
    check_eq("par_err_set", bus.parity_err, 1);
    read_pulse();
    check_eq("par_err_cleared", bus.parity_err, 0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    expect_byte("par_good");
    check_eq("par_err_clear", bus.parity_err, 0);
    read_pulse();
`endif

    check_eq("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
